servo_pwm_multi: RTL and testbench

- Multi-channel servo PWM generator on the SweRVolf Wishbone peripheral bus.
- Generalises the fixed two-channel pitch/yaw PWM to NUM_CH channels and CNT_W-bit resolution.
- Adds a runtime-programmable period, glitch-free updates at frame boundaries, and per-channel slew-rate limiting.
- Sits in swervolf_core. The outputs drive PMOD pins for the LiDAR gimbal servos.

---
 rtl/servo_pwm_pkg.sv | 22 ++
 rtl/servo_pwm_channel.sv | 73 +++++++
 rtl/servo_pwm_multi.sv | 147 ++++++++++++++
 tb/tb_servo_pwm_multi.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// Register map for the multi-channel servo PWM peripheral.
// Byte offsets on the 8-bit Wishbone address; bits [1:0] are ignored.
// Also holds the byte-enable expansion helper shared by the register files.
package servo_pwm_pkg;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_PERIOD  = 8'h04;
  localparam logic [7:0] REG_STATUS  = 8'h08;
  localparam logic [7:0] CH_BASE     = 8'h20;
  localparam logic [7:0] CH_STRIDE   = 8'h10;
  localparam logic [7:0] OFF_TARGET  = 8'h00;
  localparam logic [7:0] OFF_STEP    = 8'h04;
  localparam logic [7:0] OFF_CURRENT = 8'h08;

  localparam int CTRL_GEN_BIT = 31;

  // Expand a 4-bit byte select into a 32-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: TARGET/STEP/CURRENT registers, frame-boundary slew, compare.
// pwm_o is registered, one cycle behind cnt_i.
// Register writes merge under wmask_i; a write landing on the boundary cycle is used there.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W         = 20,
  parameter int DEFAULT_PULSE = 75000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             frame_i,
  input  logic             en_i,
  input  logic             tgt_we_i,
  input  logic             stp_we_i,
  input  logic [CNT_W-1:0] wdat_i,
  input  logic [CNT_W-1:0] wmask_i,
  output logic             pwm_o,
  output logic             settled_o,
  output logic [CNT_W-1:0] target_o,
  output logic [CNT_W-1:0] step_o,
  output logic [CNT_W-1:0] current_o
);

  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] diff;
  logic             up;
  logic             pwm_q;

  // Next-state: merged register writes, then slew CURRENT toward the (possibly just written) TARGET.
  always_comb begin
    target_d = tgt_we_i ? ((target_q & ~wmask_i) | (wdat_i & wmask_i)) : target_q;
    step_d   = stp_we_i ? ((step_q & ~wmask_i) | (wdat_i & wmask_i)) : step_q;
    up       = (target_d >= cur_q);
    // Distance is taken in the right direction so it never wraps.
    diff     = up ? (target_d - cur_q) : (cur_q - target_d);
    cur_d    = cur_q;
    if (frame_i) begin
      if ((step_d == '0) || (diff <= step_d)) begin
        cur_d = target_d;
      end else if (up) begin
        cur_d = cur_q + step_d;
      end else begin
        cur_d = cur_q - step_d;
      end
    end
  end

  // Register state and the gated compare output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= CNT_W'(DEFAULT_PULSE);
      step_q   <= '0;
      cur_q    <= CNT_W'(DEFAULT_PULSE);
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      step_q   <= step_d;
      cur_q    <= cur_d;
      pwm_q    <= en_i & (cnt_i < cur_q);
    end
  end

  assign pwm_o     = pwm_q;
  assign settled_o = (cur_q == target_q);
  assign target_o  = target_q;
  assign step_o    = step_q;
  assign current_o = cur_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM on Wishbone: bus decode, CTRL, PERIOD/shadow, frame counter.
// Ack one cycle after request, never back-to-back; o_pwm is one cycle behind cnt.
// Held strobes are acked every second cycle; writes commit on the ack cycle.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 20,
  parameter int DEFAULT_PERIOD = 1000000,
  parameter int DEFAULT_PULSE  = 75000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  input  logic              i_wb_we,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  output logic [31:0]       o_wb_rdt,
  output logic              o_wb_ack,
  output logic [NUM_CH-1:0] o_pwm,
  output logic              o_frame
);

  logic              ack_q;
  logic [31:0]       rdt_q, rdt_d, rd_mux;
  logic              gen_q, gen_d;
  logic [NUM_CH-1:0] chen_q, chen_d;
  logic [CNT_W-1:0]  period_q, period_d, period_clamped;
  logic [CNT_W-1:0]  shadow_q, cnt_q;
  logic              frame_q;
  logic              req, wr, frame_tick;
  logic [7:0]        adr, ch_base;
  logic [31:0]       mask;
  logic [NUM_CH-1:0] tgt_we, stp_we, pwm, settled;
  logic [CNT_W-1:0]  tgt_r [NUM_CH];
  logic [CNT_W-1:0]  stp_r [NUM_CH];
  logic [CNT_W-1:0]  cur_r [NUM_CH];
  logic              unused_bits;

  assign adr            = {i_wb_adr[7:2], 2'b00};
  assign req            = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr             = ack_q & i_wb_cyc & i_wb_stb & i_wb_we;
  assign mask           = byte_mask(i_wb_sel);
  assign frame_tick     = gen_q & (cnt_q == shadow_q - CNT_W'(1));
  assign period_clamped = (period_d < CNT_W'(2)) ? CNT_W'(2) : period_d;
  assign unused_bits    = ^{i_wb_adr[1:0], i_wb_dat, mask};

  // Register writes, per-channel write strobes and read-data mux.
  always_comb begin
    gen_d    = gen_q;
    chen_d   = chen_q;
    period_d = period_q;
    tgt_we   = '0;
    stp_we   = '0;
    rd_mux   = '0;
    ch_base  = '0;
    if (wr && adr == REG_CTRL) begin
      if (i_wb_sel[3]) gen_d = i_wb_dat[CTRL_GEN_BIT];
      if (i_wb_sel[0]) chen_d = i_wb_dat[NUM_CH-1:0];
    end
    if (wr && adr == REG_PERIOD) begin
      period_d = (period_q & ~mask[CNT_W-1:0]) | (i_wb_dat[CNT_W-1:0] & mask[CNT_W-1:0]);
    end
    if (adr == REG_CTRL) begin
      rd_mux[CTRL_GEN_BIT] = gen_q;
      rd_mux[NUM_CH-1:0]   = chen_q;
    end
    if (adr == REG_PERIOD) rd_mux = 32'(period_q);
    if (adr == REG_STATUS) rd_mux = 32'(settled);
    for (int c = 0; c < NUM_CH; c++) begin
      ch_base = CH_BASE + CH_STRIDE * 8'(c);
      if (adr == ch_base + OFF_TARGET) begin
        tgt_we[c] = wr;
        rd_mux    = 32'(tgt_r[c]);
      end
      if (adr == ch_base + OFF_STEP) begin
        stp_we[c] = wr;
        rd_mux    = 32'(stp_r[c]);
      end
      if (adr == ch_base + OFF_CURRENT) rd_mux = 32'(cur_r[c]);
    end
    rdt_d = req ? rd_mux : '0;
  end

  // Bus handshake, control registers and the frame counter.
  // While disabled the shadow tracks PERIOD so a fresh enable starts on the programmed period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      gen_q    <= 1'b0;
      chen_q   <= '0;
      period_q <= CNT_W'(DEFAULT_PERIOD);
      shadow_q <= CNT_W'(DEFAULT_PERIOD);
      cnt_q    <= '0;
      frame_q  <= 1'b0;
    end else begin
      ack_q    <= req;
      rdt_q    <= rdt_d;
      gen_q    <= gen_d;
      chen_q   <= chen_d;
      period_q <= period_d;
      if (!gen_q) begin
        cnt_q    <= '0;
        frame_q  <= 1'b0;
        shadow_q <= period_clamped;
      end else if (frame_tick) begin
        cnt_q    <= '0;
        frame_q  <= 1'b1;
        shadow_q <= period_clamped;
      end else begin
        cnt_q    <= cnt_q + CNT_W'(1);
        frame_q  <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_pwm_channel #(
      .CNT_W         (CNT_W),
      .DEFAULT_PULSE (DEFAULT_PULSE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cnt_i     (cnt_q),
      .frame_i   (frame_tick),
      .en_i      (gen_q & chen_q[g]),
      .tgt_we_i  (tgt_we[g]),
      .stp_we_i  (stp_we[g]),
      .wdat_i    (i_wb_dat[CNT_W-1:0]),
      .wmask_i   (mask[CNT_W-1:0]),
      .pwm_o     (pwm[g]),
      .settled_o (settled[g]),
      .target_o  (tgt_r[g]),
      .step_o    (stp_r[g]),
      .current_o (cur_r[g])
    );
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_pwm    = pwm;
  assign o_frame  = frame_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: register access, PWM frames, slewing, boundaries, reset.
// A negedge monitor measures each frame's length and ch0 high time from o_frame.
// Every scenario task compares observed values against hand-computed constants.
module tb_servo_pwm_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        wb_adr = '0;
  logic [31:0]       wb_dat = '0;
  logic [3:0]        wb_sel = '0;
  logic              wb_we = 1'b0;
  logic              wb_cyc = 1'b0;
  logic              wb_stb = 1'b0;
  logic [31:0]       o_wb_rdt;
  logic              o_wb_ack;
  logic [NUM_CH-1:0] o_pwm;
  logic              o_frame;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (1000000),
    .DEFAULT_PULSE  (75000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .i_wb_stb (wb_stb),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_pwm    (o_pwm),
    .o_frame  (o_frame)
  );

  // Frame monitor: a window starts the cycle after o_frame (pwm there reflects cnt=0)
  // and covers exactly one frame of ch0 output.
  int   mon_len = 0, mon_hi = 0, last_len = 0, last_hi = 0, nframes = 0;
  logic frm_d = 1'b0;
  always @(negedge clk) begin
    if (frm_d) begin
      last_len <= mon_len;
      last_hi  <= mon_hi;
      mon_len  <= 1;
      mon_hi   <= int'(o_pwm[0]);
      nframes  <= nframes + 1;
    end else begin
      mon_len  <= mon_len + 1;
      mon_hi   <= mon_hi + int'(o_pwm[0]);
    end
    frm_d <= o_frame;
  end

  task automatic bus(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_wb_ack && n < 8);
    rd = o_wb_rdt;
    vectors++;
    if (o_wb_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL bus_ack_timeout adr=%h got_ack=%b exp=1", adr, o_wb_ack);
    end
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    bus(adr, dat, 4'hF, 1'b1, dummy);
  endtask

  task automatic rd(input logic [7:0] adr, output logic [31:0] val);
    bus(adr, 32'h0, 4'hF, 1'b0, val);
  endtask

  task automatic wait_frames(input int n);
    int start, k;
    start = nframes;
    k = 0;
    while (nframes < start + n && k < 5000) begin
      @(posedge clk);
      k++;
    end
    vectors++;
    if (nframes < start + n) begin
      miscompares++;
      $display("FAIL frame_timeout got=%0d exp=%0d frames", nframes - start, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int hi, fr;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (o_pwm !== 2'b00) begin miscompares++; $display("FAIL rst_pwm got=%b exp=00", o_pwm); end
    vectors++; if (o_frame !== 1'b0) begin miscompares++; $display("FAIL rst_frame got=%b exp=0", o_frame); end
    vectors++; if (o_wb_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got=%b exp=0", o_wb_ack); end
    vectors++; if (o_wb_rdt !== 32'h0) begin miscompares++; $display("FAIL rst_rdt got=%h exp=0", o_wb_rdt); end
    @(negedge clk);
    rst = 1'b0;
    rd(8'h04, v);
    vectors++; if (v !== 32'd1000000) begin miscompares++; $display("FAIL rst_period got=%0d exp=1000000", v); end
    rd(8'h20, v);
    vectors++; if (v !== 32'd75000) begin miscompares++; $display("FAIL rst_target got=%0d exp=75000", v); end
    rd(8'h28, v);
    vectors++; if (v !== 32'd75000) begin miscompares++; $display("FAIL rst_current got=%0d exp=75000", v); end
    rd(8'h00, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL rst_ctrl got=%h exp=0", v); end
    rd(8'h08, v);
    vectors++; if (v !== 32'h3) begin miscompares++; $display("FAIL rst_status got=%h exp=3", v); end
    hi = 0; fr = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_pwm != 2'b00) hi++;
      if (o_frame) fr++;
    end
    vectors++; if (hi != 0 || fr != 0) begin miscompares++; $display("FAIL idle_outputs got_hi=%0d got_frames=%0d exp=0/0", hi, fr); end
  endtask

  task automatic test_bus();
    logic [31:0] v;
    logic [7:0]  pat;
    rd(8'h0C, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got=%h exp=0", v); end
    @(posedge clk); #1;
    wb_adr = 8'h04; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    pat = '0;
    repeat (8) begin
      @(posedge clk); #1;
      pat = {pat[6:0], o_wb_ack};
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    vectors++; if (pat !== 8'b10101010) begin miscompares++; $display("FAIL held_stb_acks got=%b exp=10101010", pat); end
    bus(8'h30, 32'hFFFF_FFAA, 4'b0001, 1'b1, v);
    rd(8'h30, v);
    vectors++; if (v !== 32'h124AA) begin miscompares++; $display("FAIL sel_write got=%h exp=124aa", v); end
  endtask

  task automatic test_basic_pwm();
    wr(8'h04, 32'd100);
    wr(8'h20, 32'd30);
    wr(8'h00, 32'h8000_0001);
    vectors++; if (o_pwm[0] !== 1'b0) begin miscompares++; $display("FAIL enable_edge0 got=%b exp=0", o_pwm[0]); end
    @(posedge clk); #1;
    vectors++; if (o_pwm[0] !== 1'b1) begin miscompares++; $display("FAIL enable_edge1 got=%b exp=1", o_pwm[0]); end
    wait_frames(2);
    vectors++; if (last_len != 100 || last_hi != 30) begin miscompares++; $display("FAIL basic_frame1 got=%0d/%0d exp=100/30", last_len, last_hi); end
    wait_frames(1);
    vectors++; if (last_len != 100 || last_hi != 30) begin miscompares++; $display("FAIL basic_frame2 got=%0d/%0d exp=100/30", last_len, last_hi); end
  endtask

  task automatic test_slew();
    logic [31:0] v, s;
    wr(8'h20, 32'd70);
    wr(8'h24, 32'd15);
    wait_frames(1);
    rd(8'h28, v); rd(8'h08, s);
    vectors++; if (v !== 32'd45 || s[0] !== 1'b0) begin miscompares++; $display("FAIL slew_45 got=%0d st=%b exp=45 st=0", v, s[0]); end
    wait_frames(1);
    rd(8'h28, v); rd(8'h08, s);
    vectors++; if (v !== 32'd60 || s[0] !== 1'b0) begin miscompares++; $display("FAIL slew_60 got=%0d st=%b exp=60 st=0", v, s[0]); end
    vectors++; if (last_hi != 45) begin miscompares++; $display("FAIL slew_width45 got=%0d exp=45", last_hi); end
    wait_frames(1);
    rd(8'h28, v); rd(8'h08, s);
    vectors++; if (v !== 32'd70 || s[0] !== 1'b1) begin miscompares++; $display("FAIL slew_70 got=%0d st=%b exp=70 st=1", v, s[0]); end
    wr(8'h24, 32'd100);
    wr(8'h20, 32'd0);
    wait_frames(1);
    rd(8'h28, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL slew_down got=%0d exp=0", v); end
    wait_frames(1);
    vectors++; if (last_len != 100 || last_hi != 0) begin miscompares++; $display("FAIL zero_width got=%0d/%0d exp=100/0", last_len, last_hi); end
  endtask

  task automatic test_midframe();
    wr(8'h20, 32'd30);
    wait_frames(1);
    repeat (35) @(posedge clk);
    wr(8'h04, 32'd50);
    wr(8'h20, 32'd20);
    wait_frames(1);
    vectors++; if (last_len != 100 || last_hi != 30) begin miscompares++; $display("FAIL midframe_old got=%0d/%0d exp=100/30", last_len, last_hi); end
    wait_frames(1);
    vectors++; if (last_len != 50 || last_hi != 20) begin miscompares++; $display("FAIL midframe_new got=%0d/%0d exp=50/20", last_len, last_hi); end
  endtask

  task automatic test_bounds();
    wr(8'h04, 32'd100);
    wr(8'h20, 32'd120);
    wait_frames(2);
    vectors++; if (last_len != 100 || last_hi != 100) begin miscompares++; $display("FAIL full_duty got=%0d/%0d exp=100/100", last_len, last_hi); end
    wr(8'h04, 32'd1);
    wait_frames(2);
    vectors++; if (last_len != 2 || last_hi != 2) begin miscompares++; $display("FAIL period_clamp got=%0d/%0d exp=2/2", last_len, last_hi); end
    wr(8'h04, 32'd100);
    wr(8'h20, 32'd60);
    wr(8'h00, 32'h8000_0000);
    wait_frames(2);
    vectors++; if (last_len != 100 || last_hi != 0) begin miscompares++; $display("FAIL ch_gated got=%0d/%0d exp=100/0", last_len, last_hi); end
    wr(8'h00, 32'h8000_0001);
    wait_frames(2);
    vectors++; if (last_len != 100 || last_hi != 60) begin miscompares++; $display("FAIL ch_slewed_while_gated got=%0d/%0d exp=100/60", last_len, last_hi); end
  endtask

  task automatic test_disable();
    int n, hi, fr;
    logic first;
    repeat (10) @(posedge clk);
    wr(8'h00, 32'h0000_0001);
    vectors++; if (o_pwm[0] !== 1'b1) begin miscompares++; $display("FAIL disable_edge0 got=%b exp=1", o_pwm[0]); end
    @(posedge clk); #1;
    vectors++; if (o_pwm[0] !== 1'b0) begin miscompares++; $display("FAIL disable_edge1 got=%b exp=0", o_pwm[0]); end
    hi = 0; fr = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (o_pwm[0]) hi++;
      if (o_frame) fr++;
    end
    vectors++; if (hi != 0 || fr != 0) begin miscompares++; $display("FAIL disabled_idle got_hi=%0d got_frames=%0d exp=0/0", hi, fr); end
    wr(8'h00, 32'h8000_0001);
    n = 0; first = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) first = o_pwm[0];
    end while (!o_frame && n < 300);
    vectors++; if (first !== 1'b1) begin miscompares++; $display("FAIL reenable_first got=%b exp=1", first); end
    vectors++; if (n != 100) begin miscompares++; $display("FAIL reenable_cnt0 got=%0d exp=100 cycles", n); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    int nf;
    repeat (57) @(posedge clk);
    #1;
    vectors++; if (o_pwm[0] !== 1'b1) begin miscompares++; $display("FAIL pre_reset_pwm got=%b exp=1", o_pwm[0]); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (o_pwm !== 2'b00 || o_frame !== 1'b0 || o_wb_ack !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got=%b/%b/%b exp=00/0/0", o_pwm, o_frame, o_wb_ack);
    end
    nf = nframes;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(8'h04, v);
    vectors++; if (v !== 32'd1000000) begin miscompares++; $display("FAIL rst2_period got=%0d exp=1000000", v); end
    rd(8'h20, v);
    vectors++; if (v !== 32'd75000) begin miscompares++; $display("FAIL rst2_target got=%0d exp=75000", v); end
    rd(8'h24, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL rst2_step got=%0d exp=0", v); end
    rd(8'h28, v);
    vectors++; if (v !== 32'd75000) begin miscompares++; $display("FAIL rst2_current got=%0d exp=75000", v); end
    rd(8'h00, v);
    vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL rst2_ctrl got=%h exp=0", v); end
    repeat (150) @(posedge clk);
    #1;
    vectors++; if (nframes != nf || o_pwm !== 2'b00) begin
      miscompares++; $display("FAIL post_reset_quiet got_frames=%0d pwm=%b exp=0/00", nframes - nf, o_pwm);
    end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_basic_pwm();
    test_slew();
    test_midframe();
    test_bounds();
    test_disable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
